// File: rtl/child_stream_collector_pkg.sv
// Shared types and helpers for the child stream fan-in levels.
package child_stream_pkg;

  localparam int NUM_CHILDREN_DEF = 10;
  localparam int DATA_W_DEF       = 32;

  typedef enum logic {ARB, LOCKED} coll_state_e;

  // Increment an index modulo n (n-1 wraps to 0).
  function automatic int next_idx(input int idx, input int n = NUM_CHILDREN_DEF);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/child_stream_collector_rr_pick_first.sv
// Rotating priority picker: first requester at or after ptr, wrapping.
// Purely combinational so it can be reused by other fan-in levels.
module rr_pick_first
  import child_stream_pkg::*;
#(
  parameter int N     = NUM_CHILDREN_DEF,
  parameter int SRC_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  int tgt;

  // Walk offsets 0..N-1 from ptr and take the first asserted request.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    tgt   = 0;
    for (int k = 0; k < N; k++) begin
      tgt = int'(ptr) + k;
      if (tgt >= N) tgt = tgt - N;
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && (i == tgt)) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = SRC_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/child_stream_collector.sv
// N-to-1 packet-locking round-robin collector with a registered,
// source-tagged output stage and a saturating packet counter.
//
// state  | meaning
// ARB    | no packet in flight; round-robin from rr_ptr
// LOCKED | mid-packet; only lock_idx may be granted until its last beat
module child_stream_collector
  import child_stream_pkg::*;
#(
  parameter int NUM_CHILDREN = NUM_CHILDREN_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int SRC_W        = $clog2(NUM_CHILDREN),
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  input  logic [NUM_CHILDREN-1:0]        child_last,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic [SRC_W-1:0]               out_src,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [CNT_W-1:0]               pkt_count,
  output logic                           busy
);

  coll_state_e             state_q, state_d;
  logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]        lock_idx_q, lock_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;
  logic                    out_last_q, out_last_d;
  logic [CNT_W-1:0]        pkt_count_q, pkt_count_d;

  logic [NUM_CHILDREN-1:0] arb_grant, grant;
  logic [SRC_W-1:0]        arb_idx, sel_idx;
  logic                    arb_any;
  logic                    load_en, accept, sel_last;
  logic [DATA_W-1:0]       sel_data;

  rr_pick_first #(.N(NUM_CHILDREN), .SRC_W(SRC_W)) u_pick (
    .req   (child_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign load_en     = !out_valid_q || out_ready;
  assign child_ready = (rst_n && load_en) ? grant : '0;
  assign accept      = |child_ready;

  // Payload and last flag of the selected child.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (sel_idx == SRC_W'(i)) begin
        sel_data = child_data[i*DATA_W +: DATA_W];
        sel_last = child_last[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // FSM next state: lock on a non-last beat, release and advance on last.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      if (sel_last) begin
        state_d  = ARB;
        rr_ptr_d = SRC_W'(next_idx(int'(sel_idx), NUM_CHILDREN));
      end else begin
        state_d    = LOCKED;
        lock_idx_d = sel_idx;
      end
    end
  end

  // FSM outputs: which child may be granted in the current state.
  always_comb begin
    grant   = '0;
    sel_idx = arb_idx;
    case (state_q)
      ARB: begin
        if (arb_any) grant = arb_grant;
      end
      LOCKED: begin
        sel_idx = lock_idx_q;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
          if (lock_idx_q == SRC_W'(i)) grant[i] = child_valid[i];
        end
      end
      default: ;
    endcase
  end

  // Output register and packet counter next values.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    if (load_en) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = sel_data;
        out_src_d  = sel_idx;
        out_last_d = sel_last;
      end
    end
    pkt_count_d = pkt_count_q;
    if (out_valid_q && out_ready && out_last_q && (pkt_count_q != {CNT_W{1'b1}}))
      pkt_count_d = pkt_count_q + 1'b1;
  end

  // Output register and packet counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign pkt_count = pkt_count_q;
  assign busy      = (state_q == LOCKED) || out_valid_q;

endmodule

// File: tb/tb_child_stream_collector.sv
// Directed bench for child_stream_collector (default parameters).
module tb_child_stream_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   cv;
  logic [319:0] cd;
  logic [9:0]   cl;
  logic [9:0]   child_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [3:0]   out_src;
  logic         out_last;
  logic         ordy;
  logic [15:0]  pkt_count;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int proto_err = 0;
  logic reached;

  logic [9:0]   pv, pr, pl;
  logic [319:0] pd;

  child_stream_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (cv),
    .child_data  (cd),
    .child_last  (cl),
    .child_ready (child_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_last    (out_last),
    .out_ready   (ordy),
    .pkt_count   (pkt_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_child(input int i, input logic v, input logic [31:0] d, input logic l);
    cv[i]         = v;
    cd[i*32 +: 32] = d;
    cl[i]         = l;
  endtask

  // Child-side protocol: a pending beat must stay valid and stable until accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0; pr <= '0; pd <= '0; pl <= '0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (pv[i] && !pr[i]) begin
          assert (cv[i] && (cd[i*32 +: 32] == pd[i*32 +: 32]) && (cl[i] == pl[i])) else begin
            proto_err <= proto_err + 1;
            $error("FAIL child_protocol child=%0d observed_valid=%0b observed_data=%0h expected_data=%0h",
                   i, cv[i], cd[i*32 +: 32], pd[i*32 +: 32]);
          end
        end
      end
      pv <= cv; pr <= child_ready; pd <= cd; pl <= cl;
    end
  end

  initial begin
    rst_n = 1'b0;
    ordy  = 1'b1;
    cv = '0; cd = '0; cl = '0;
    for (int i = 0; i < 10; i++) set_child(i, 1'b1, 32'h100 + i, 1'b1);

    // Reset state, with every child requesting.
    repeat (2) @(negedge clk);
    chk("rst_ready", child_ready, 10'h000);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_src", out_src, 0);
    chk("rst_last", out_last, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_busy", busy, 0);

    // All ten children, single-beat packets: strict rotation 0..9,0..
    rst_n = 1'b1;
    #1 chk("rr_ready0", child_ready, 10'h001);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("rr_valid", out_valid, 1);
      chk("rr_src", out_src, (k - 1) % 10);
      chk("rr_data", out_data, 32'h100 + ((k - 1) % 10));
      chk("rr_pkt", pkt_count, k - 1);
      chk("rr_ready", child_ready, (k == 20) ? 10'h200 : (10'h001 << (k % 10)));
      if (k >= 11) cv[(k - 1) % 10] = 1'b0;
    end
    @(negedge clk);
    chk("rr_drain_valid", out_valid, 0);
    chk("rr_drain_pkt", pkt_count, 20);
    chk("rr_drain_busy", busy, 0);

    // Child 2 once to move rr_ptr to 3, then a 4-beat packet from child 3
    // while children 2 and 5 wait.
    set_child(2, 1'b1, 32'h22, 1'b1);
    #1 chk("lk_setup_ready", child_ready, 10'h004);
    @(negedge clk);
    chk("lk_setup_src", out_src, 2);
    chk("lk_setup_data", out_data, 32'h22);
    set_child(2, 1'b1, 32'hB2, 1'b1);
    set_child(3, 1'b1, 32'hA0, 1'b0);
    set_child(5, 1'b1, 32'hB5, 1'b1);
    #1 chk("lk_first_ready", child_ready, 10'h008);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("lk_src", out_src, 3);
      chk("lk_data", out_data, 32'hA0 + b);
      chk("lk_last", out_last, (b == 3) ? 1 : 0);
      chk("lk_busy", busy, 1);
      chk("lk_ready", child_ready, (b == 3) ? 10'h020 : 10'h008);
      if (b < 3) set_child(3, 1'b1, 32'hA1 + b, (b == 2) ? 1'b1 : 1'b0);
      else cv[3] = 1'b0;
    end
    @(negedge clk);
    chk("lk_next5_src", out_src, 5);
    chk("lk_next5_data", out_data, 32'hB5);
    chk("lk_next5_ready", child_ready, 10'h004);
    cv[5] = 1'b0;
    @(negedge clk);
    chk("lk_next2_src", out_src, 2);
    chk("lk_next2_data", out_data, 32'hB2);
    cv[2] = 1'b0;
    @(negedge clk);
    chk("lk_end_valid", out_valid, 0);
    chk("lk_end_pkt", pkt_count, 24);

    // Backpressure: 0x1234 from child 7 held for five cycles, child 8 waiting.
    set_child(7, 1'b1, 32'h1234, 1'b1);
    set_child(8, 1'b1, 32'h5678, 1'b1);
    #1 chk("bp_ready_7", child_ready, 10'h080);
    @(negedge clk);
    chk("bp_first_data", out_data, 32'h1234);
    cv[7] = 1'b0;
    ordy  = 1'b0;
    #1 chk("bp_stall_ready0", child_ready, 10'h000);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 32'h1234);
      chk("bp_hold_src", out_src, 7);
      chk("bp_hold_last", out_last, 1);
      chk("bp_hold_ready", child_ready, 10'h000);
      chk("bp_hold_pkt", pkt_count, 24);
    end
    ordy = 1'b1;
    #1 chk("bp_release_ready", child_ready, 10'h100);
    @(negedge clk);
    chk("bp_next_src", out_src, 8);
    chk("bp_next_data", out_data, 32'h5678);
    chk("bp_next_pkt", pkt_count, 25);
    cv[8] = 1'b0;
    @(negedge clk);
    chk("bp_end_valid", out_valid, 0);
    chk("bp_end_pkt", pkt_count, 26);

    // Wrap: child 9 alone, then child 0 alone, then 0 and 1 together (ptr=1).
    set_child(9, 1'b1, 32'h99, 1'b1);
    #1 chk("wr_ready9", child_ready, 10'h200);
    @(negedge clk);
    chk("wr_src9", out_src, 9);
    cv[9] = 1'b0;
    set_child(0, 1'b1, 32'h0A, 1'b1);
    #1 chk("wr_ready0", child_ready, 10'h001);
    @(negedge clk);
    chk("wr_src0", out_src, 0);
    chk("wr_data0", out_data, 32'h0A);
    chk("wr_pkt", pkt_count, 27);
    set_child(0, 1'b1, 32'hC0, 1'b1);
    set_child(1, 1'b1, 32'hC1, 1'b1);
    #1 chk("wr_ptr1_ready", child_ready, 10'h002);
    @(negedge clk);
    chk("wr_src1", out_src, 1);
    chk("wr_ptr2_ready", child_ready, 10'h001);
    cv[1] = 1'b0;
    @(negedge clk);
    chk("wr_srcC0", out_data, 32'hC0);
    chk("wr_pkt2", pkt_count, 29);
    cv[0] = 1'b0;
    @(negedge clk);
    chk("wr_end_valid", out_valid, 0);

    // Reset in the middle of a 4-beat packet from child 6.
    set_child(6, 1'b1, 32'h60, 1'b0);
    #1 chk("mr_ready6", child_ready, 10'h040);
    @(negedge clk);
    chk("mr_beat0", out_data, 32'h60);
    set_child(6, 1'b1, 32'h61, 1'b0);
    @(negedge clk);
    chk("mr_beat1", out_data, 32'h61);
    chk("mr_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_src", out_src, 0);
    chk("mr_last", out_last, 0);
    chk("mr_pkt", pkt_count, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_ready", child_ready, 10'h000);
    set_child(6, 1'b1, 32'h62, 1'b1);
    set_child(1, 1'b1, 32'h11, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr_restart_ready", child_ready, 10'h002);
    @(negedge clk);
    chk("mr_first_src", out_src, 1);
    chk("mr_first_data", out_data, 32'h11);
    chk("mr_first_pkt", pkt_count, 0);
    chk("mr_unlock_ready", child_ready, 10'h040);
    cv[1] = 1'b0;
    @(negedge clk);
    chk("mr_second_src", out_src, 6);
    chk("mr_second_data", out_data, 32'h62);
    cv[6] = 1'b0;
    @(negedge clk);
    chk("mr_end_pkt", pkt_count, 2);

    // Saturation: stream child 0 until the counter reaches 0xFFFE, then 3 more.
    set_child(0, 1'b1, 32'hF0, 1'b1);
    reached = 1'b0;
    for (int n = 0; n < 70000; n++) begin
      @(negedge clk);
      if (pkt_count == 16'hFFFE) begin
        reached = 1'b1;
        break;
      end
    end
    chk("sat_reach_fffe", reached, 1);
    repeat (3) @(negedge clk);
    chk("sat_ffff", pkt_count, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("sat_hold", pkt_count, 16'hFFFF);
    cv[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("sat_final", pkt_count, 16'hFFFF);

    chk("child_protocol", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/child_stream_collector.md
Name: child_stream_collector

Overview:
- N-to-1 fan-in stage directly downstream of the 10-instance root hierarchy level.
- Merges the per-instance result streams (inst_0..inst_9) into one registered output stream.
- Uses round-robin fairness with packet locking (grant held until last beat).
- Tags each output beat with its source index for the next level up.

Parameters:
NUM_CHILDREN, 10, number of child input streams (must be 2..16)
DATA_W, 32, payload width per beat
SRC_W, $clog2(NUM_CHILDREN), source-index width (4 at default)
CNT_W, 16, width of per-collector packet counter

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
child_valid  input  NUM_CHILDREN  beat valid per child
child_data  input  NUM_CHILDREN*DATA_W  packed payloads, child i at [i*DATA_W +: DATA_W]
child_last  input  NUM_CHILDREN  final beat of packet per child
child_ready  output  NUM_CHILDREN  beat accepted from child i when valid&ready
out_valid  output  1  registered output beat valid
out_data  output  DATA_W  registered payload
out_src  output  SRC_W  index of child that produced beat
out_last  output  1  final beat of packet
out_ready  input  1  downstream accept
pkt_count  output  CNT_W  completed packets forwarded, saturating
busy  output  1  high in LOCKED state or when out_valid

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_src=0, out_last=0, pkt_count=0, rr_ptr=0, lock_idx=0, state=ARB; child_ready=0 while in reset.
- Output register: load_en = !out_valid || out_ready. child_ready[i] = load_en && grant[i]. Exactly one child_ready bit high at most.
- Latency: accepted child beat appears on out_* the next cycle. Full throughput of 1 beat/cycle when out_ready stays high.
- out_* hold stable while out_valid && !out_ready. A valid beat is never dropped or duplicated.
- State ARB:
  - grant = first i with child_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_CHILDREN.
  - Accepted beat with child_last=1: stay ARB, rr_ptr <= (i+1) mod NUM_CHILDREN (9 wraps to 0).
  - Accepted beat with child_last=0: go LOCKED, lock_idx <= i.
  - No valid child: hold rr_ptr.
- State LOCKED:
  - grant only lock_idx, and only when child_valid[lock_idx]. Other children are not granted even if valid.
  - Accepted beat with last=1: go ARB, rr_ptr <= (lock_idx+1) mod NUM_CHILDREN.
- pkt_count:
  - Increments when out_valid && out_ready && out_last.
  - Saturates at 2^CNT_W-1.
- Simultaneous events: output drain and new load in the same cycle are allowed (load_en true via out_ready).
- Fairness: a continuously valid child is granted within NUM_CHILDREN-1 completed packets.
- Reset mid-packet: clears lock, discards the registered beat, and restarts arbitration at child 0.
- Child protocol is required (assertions in bench): child_data/last stable while valid && !ready; valid not withdrawn before ready.

Decomposition:
- Package child_stream_pkg:
  - localparams NUM_CHILDREN_DEF=10, DATA_W_DEF=32.
  - typedef enum logic {ARB, LOCKED} coll_state_e.
  - function next_idx(idx) for mod-N increment.
- Sub-module rr_pick_first:
  - Combinational rotate-from-pointer priority picker.
  - Inputs req[N], ptr. Outputs onehot grant[N], idx[SRC_W], any.
  - Reused for future fan-in levels of the hierarchy.

Test Plan:
- Reset then all 10 children valid with single-beat packets (last=1), out_ready=1 -> out_src sequence 0,1,...,9,0 on consecutive cycles; pkt_count=10 after 10 beats.
- Child 3 sends a 4-beat packet (data 0xA0..0xA3) while children 2 and 5 are valid -> four consecutive beats with out_src=3, data A0..A3, last on A3; then child 5 is granted (rr_ptr=4), then child 2.
- out_ready held low 5 cycles with out_valid=1 (data 0x1234, src 7) -> out_* stable, all child_ready=0; first cycle with out_ready=1 transfers 0x1234 and loads the next beat the same edge.
- Only child 9 valid, single beat; next only child 0 valid -> grant 9 then 0; rr_ptr wraps to 0 then 1.
- Assert rst_n=0 in LOCKED after 2 of 4 beats from child 6 -> outputs zero asynchronously; after release, child 1 valid -> out_src=1 first, pkt_count=0.
- Force pkt_count to 0xFFFE by preloading/long run, send 3 packets -> pkt_count stays at 0xFFFF.
